axi4_rom_read_slave: RTL and testbench

AXI4 read-only slave (responder) that serves AR/R burst requests from a synchronous-read block memory. It sits at the far end of the instruction-cache AXI4 read master and acts as the instruction/boot memory on FPGA and in simulation. It is fully pipelined: one R beat per cycle when RREADY is held high. It supports FIXED and INCR bursts and returns error responses for unsupported or out-of-range accesses.

---
 rtl/axi4_rom_read_slave.sv | 174 +++++++++++++++++
 tb/tb_axi4_rom_read_slave.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rom_read_slave.sv
// ============================================================================
// Module   : axi4_rom_read_slave
// Purpose  : AXI4 read-only responder serving FIXED/INCR bursts from a
//            synchronous-read block memory, one R beat per cycle.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi4_rom_read_slave #(
   parameter int                         C_ADDRESS_WIDTH = 32,
   parameter int                         C_DATA_WIDTH    = 32,
   parameter int                         C_MEM_DEPTH     = 4096,
   parameter logic [C_ADDRESS_WIDTH-1:0] C_BASE_ADDR     = 32'h0000_0000
) (
   input  logic                           CLK,
   input  logic                           RES_N,
   input  logic [C_ADDRESS_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [7:0]                     S_AXI_ARLEN,
   input  logic [2:0]                     S_AXI_ARSIZE,
   input  logic [1:0]                     S_AXI_ARBURST,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [C_DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RLAST,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [$clog2(C_MEM_DEPTH)-1:0] MEM_ADDR,
   output logic                           MEM_EN,
   input  logic [C_DATA_WIDTH-1:0]        MEM_DOUT
);

   localparam int c_BYTE_SHIFT = $clog2(C_DATA_WIDTH/8);
   localparam int c_MEM_AW     = $clog2(C_MEM_DEPTH);
   localparam int c_WW         = C_ADDRESS_WIDTH + 1;

   localparam logic [C_ADDRESS_WIDTH-1:0] c_DEPTH = C_ADDRESS_WIDTH'(C_MEM_DEPTH);

   localparam logic [0:0] c_S_IDLE  = 1'b0;
   localparam logic [0:0] c_S_BURST = 1'b1;

   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;
   localparam logic [1:0] c_RESP_DECERR = 2'b11;

   logic [0:0]      r_state;
   logic            r_arready;
   logic            r_rvalid;
   logic            r_rlast;
   logic [1:0]      r_rresp;
   logic [7:0]      r_len;
   logic [7:0]      r_beat;
   logic [7:0]      r_left;
   logic            r_incr;
   logic            r_slverr;
   logic [c_WW-1:0] r_word;

   logic                   w_ar_hs;
   logic                   w_r_hs;
   logic                   w_issue;
   logic                   w_ar_slverr;
   logic                   w_ar_decerr;
   logic                   w_cur_decerr;
   logic signed [c_WW-1:0] w_ar_diff;
   logic signed [c_WW-1:0] w_ar_word;

   // Word index is kept one bit wider than the address and signed so that
   // addresses below the base show up as negative and decode to DECERR.
   function automatic logic f_decerr(input logic [c_WW-1:0] i_word);
      return i_word[c_WW-1] | (i_word[c_WW-2:0] >= c_DEPTH);
   endfunction

   function automatic logic [1:0] f_resp(input logic i_slv, input logic i_dec);
      if (i_slv)
         return c_RESP_SLVERR;
      else if (i_dec)
         return c_RESP_DECERR;
      else
         return c_RESP_OKAY;
   endfunction

   assign w_ar_hs      = S_AXI_ARVALID & r_arready;
   assign w_r_hs       = r_rvalid & S_AXI_RREADY;
   assign w_ar_slverr  = (S_AXI_ARSIZE != 3'(c_BYTE_SHIFT)) | S_AXI_ARBURST[1];
   assign w_ar_diff    = $signed({1'b0, S_AXI_ARADDR} - {1'b0, C_BASE_ADDR});
   assign w_ar_word    = w_ar_diff >>> c_BYTE_SHIFT;
   assign w_ar_decerr  = f_decerr(w_ar_word);
   assign w_cur_decerr = f_decerr(r_word);

   assign w_issue = (r_state == c_S_BURST) && (r_left != 8'd0) &&
                    (!r_rvalid || S_AXI_RREADY);

   // The first beat is fetched in the AR handshake cycle straight from ARADDR.
   always_comb begin
      MEM_EN   = 1'b0;
      MEM_ADDR = r_word[c_MEM_AW-1:0];
      if (w_ar_hs) begin
         MEM_EN   = !w_ar_slverr && !w_ar_decerr;
         MEM_ADDR = w_ar_word[c_MEM_AW-1:0];
      end else if (w_issue) begin
         MEM_EN   = !r_slverr && !w_cur_decerr;
      end
   end

   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RLAST   = r_rlast;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = (r_rresp == c_RESP_OKAY) ? MEM_DOUT : '0;

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         r_state   <= c_S_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= c_RESP_OKAY;
         r_len     <= 8'd0;
         r_beat    <= 8'd0;
         r_left    <= 8'd0;
         r_incr    <= 1'b0;
         r_slverr  <= 1'b0;
         r_word    <= '0;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (w_ar_hs) begin
                  r_state   <= c_S_BURST;
                  r_arready <= 1'b0;
                  r_len     <= S_AXI_ARLEN;
                  r_left    <= S_AXI_ARLEN;
                  r_beat    <= 8'd1;
                  r_incr    <= (S_AXI_ARBURST == 2'b01);
                  r_slverr  <= w_ar_slverr;
                  r_word    <= (S_AXI_ARBURST == 2'b01) ? w_ar_word + c_WW'(1) : w_ar_word;
                  r_rvalid  <= 1'b1;
                  r_rlast   <= (S_AXI_ARLEN == 8'd0);
                  r_rresp   <= f_resp(w_ar_slverr, w_ar_decerr);
               end else begin
                  r_arready <= 1'b1;
               end
            end
            c_S_BURST: begin
               if (w_issue) begin
                  r_rvalid <= 1'b1;
                  r_rlast  <= (r_beat == r_len);
                  r_rresp  <= f_resp(r_slverr, w_cur_decerr);
                  r_beat   <= r_beat + 8'd1;
                  r_left   <= r_left - 8'd1;
                  if (r_incr)
                     r_word <= r_word + c_WW'(1);
               end else if (S_AXI_RREADY) begin
                  r_rvalid <= 1'b0;
                  r_rlast  <= 1'b0;
               end
               if (w_r_hs && r_rlast) begin
                  r_state   <= c_S_IDLE;
                  r_arready <= 1'b1;
               end
            end
            default: begin
               r_state   <= c_S_IDLE;
               r_arready <= 1'b0;
               r_rvalid  <= 1'b0;
               r_rlast   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi4_rom_read_slave.sv
// ============================================================================
// Module   : tb_axi4_rom_read_slave
// Purpose  : Randomised self-checking bench for axi4_rom_read_slave.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi4_rom_read_slave;

   localparam int     c_DEPTH = 4096;
   localparam longint c_BASE  = 0;

   logic        CLK;
   logic        RES_N;
   logic [31:0] S_AXI_ARADDR;
   logic [7:0]  S_AXI_ARLEN;
   logic [2:0]  S_AXI_ARSIZE;
   logic [1:0]  S_AXI_ARBURST;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RLAST;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [11:0] MEM_ADDR;
   logic        MEM_EN;
   logic [31:0] MEM_DOUT;

   logic [31:0] mem [0:c_DEPTH-1];

   int errors = 0;
   int checks = 0;

   axi4_rom_read_slave u_dut (
      .CLK           (CLK),
      .RES_N         (RES_N),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARLEN   (S_AXI_ARLEN),
      .S_AXI_ARSIZE  (S_AXI_ARSIZE),
      .S_AXI_ARBURST (S_AXI_ARBURST),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RLAST   (S_AXI_RLAST),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .MEM_ADDR      (MEM_ADDR),
      .MEM_EN        (MEM_EN),
      .MEM_DOUT      (MEM_DOUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous-read block RAM: output holds while MEM_EN is low.
   always @(posedge CLK) begin
      if (MEM_EN)
         MEM_DOUT <= mem[MEM_ADDR];
   end

   function automatic logic rready_for(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Full burst: AR handshake, beat collection against the reference model,
   // stall stability, MEM_EN accounting and ARREADY return.
   task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int mode, input string name);
      logic [31:0] exp_d [$];
      logic [1:0]  exp_r [$];
      logic [31:0] held_d;
      logic [1:0]  held_r;
      logic        held_l;
      logic        stalled;
      logic        done;
      int          okay_cnt;
      int          en_cnt;
      int          idx;
      int          t;
      okay_cnt = 0;
      en_cnt   = 0;
      idx      = 0;
      stalled  = 1'b0;
      done     = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         longint ba;
         longint wd;
         ba = {32'd0, addr[31:2], 2'b00};
         if (burst == 2'b01)
            ba = ba + 4 * k;
         wd = (ba - c_BASE) / 4;
         if (size != 3'd2 || burst[1]) begin
            exp_d.push_back(32'd0);
            exp_r.push_back(2'b10);
         end else if (ba < c_BASE || wd >= c_DEPTH) begin
            exp_d.push_back(32'd0);
            exp_r.push_back(2'b11);
         end else begin
            exp_d.push_back(mem[int'(wd)]);
            exp_r.push_back(2'b00);
            okay_cnt++;
         end
      end

      t = 0;
      while (!S_AXI_ARREADY && t < 20) begin
         @(negedge CLK);
         t++;
      end
      checks++;
      if (S_AXI_ARREADY !== 1'b1) begin
         errors++;
         $display("FAIL %s arready_wait: ARREADY=%b required 1", name, S_AXI_ARREADY);
      end
      S_AXI_ARADDR  = addr;
      S_AXI_ARLEN   = len;
      S_AXI_ARSIZE  = size;
      S_AXI_ARBURST = burst;
      S_AXI_ARVALID = 1'b1;
      S_AXI_RREADY  = 1'b0;
      #1;
      if (MEM_EN) en_cnt++;
      @(negedge CLK);
      S_AXI_ARVALID = 1'b0;
      S_AXI_ARADDR  = $urandom;
      S_AXI_ARLEN   = 8'($urandom);
      checks++;
      if (S_AXI_RVALID !== 1'b1) begin
         errors++;
         $display("FAIL %s latency: RVALID=%b one cycle after AR, required 1", name, S_AXI_RVALID);
      end

      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         S_AXI_RREADY = rready_for(mode, cyc);
         #1;
         if (MEM_EN) en_cnt++;
         if (stalled) begin
            checks++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== held_d ||
                S_AXI_RRESP !== held_r || S_AXI_RLAST !== held_l) begin
               errors++;
               $display("FAIL %s stall_hold: got v=%b d=%h r=%b l=%b required v=1 d=%h r=%b l=%b",
                        name, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
                        held_d, held_r, held_l);
            end
         end
         stalled = S_AXI_RVALID && !S_AXI_RREADY;
         if (stalled) begin
            held_d = S_AXI_RDATA;
            held_r = S_AXI_RRESP;
            held_l = S_AXI_RLAST;
            checks++;
            if (MEM_EN !== 1'b0) begin
               errors++;
               $display("FAIL %s stall_mem_en: MEM_EN=%b during stall, required 0", name, MEM_EN);
            end
         end
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            checks++;
            if (idx > int'(len)) begin
               errors++;
               $display("FAIL %s extra_beat: beat %0d beyond len %0d", name, idx, len);
            end else if (S_AXI_RDATA !== exp_d[idx] || S_AXI_RRESP !== exp_r[idx] ||
                         S_AXI_RLAST !== (idx == int'(len))) begin
               errors++;
               $display("FAIL %s beat%0d: got d=%h r=%b l=%b required d=%h r=%b l=%b",
                        name, idx, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
                        exp_d[idx], exp_r[idx], (idx == int'(len)));
            end
            idx++;
            if (idx > int'(len)) done = 1'b1;
         end
         @(negedge CLK);
      end
      S_AXI_RREADY = 1'b0;

      checks++;
      if (idx != int'(len) + 1) begin
         errors++;
         $display("FAIL %s beat_count: got %0d beats required %0d", name, idx, int'(len) + 1);
      end
      checks++;
      if (S_AXI_ARREADY !== 1'b1 || S_AXI_RVALID !== 1'b0) begin
         errors++;
         $display("FAIL %s end_state: ARREADY=%b RVALID=%b required 1/0", name,
                  S_AXI_ARREADY, S_AXI_RVALID);
      end
      checks++;
      if (en_cnt != okay_cnt) begin
         errors++;
         $display("FAIL %s mem_en_count: got %0d pulses required %0d", name, en_cnt, okay_cnt);
      end
   endtask

   task automatic test_reset();
      RES_N = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (S_AXI_ARREADY !== 1'b0 || S_AXI_RVALID !== 1'b0 ||
          S_AXI_RLAST !== 1'b0 || S_AXI_RRESP !== 2'b00) begin
         errors++;
         $display("FAIL reset_values: ar=%b v=%b l=%b r=%b required 0 0 0 00",
                  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, S_AXI_RRESP);
      end
      RES_N = 1'b1;
      #1;
      checks++;
      if (S_AXI_ARREADY !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ARREADY=%b before first edge, required 0", S_AXI_ARREADY);
      end
      @(negedge CLK);
      checks++;
      if (S_AXI_ARREADY !== 1'b1) begin
         errors++;
         $display("FAIL reset_arready: ARREADY=%b after first edge, required 1", S_AXI_ARREADY);
      end
   endtask

   task automatic test_reset_mid_burst();
      S_AXI_ARADDR  = 32'h0;
      S_AXI_ARLEN   = 8'd7;
      S_AXI_ARSIZE  = 3'd2;
      S_AXI_ARBURST = 2'b01;
      S_AXI_ARVALID = 1'b1;
      @(negedge CLK);
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== mem[3]) begin
         errors++;
         $display("FAIL midrst_beat3: v=%b d=%h required 1 %h", S_AXI_RVALID, S_AXI_RDATA, mem[3]);
      end
      RES_N = 1'b0;
      #1;
      checks++;
      if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b0) begin
         errors++;
         $display("FAIL midrst_assert: RVALID=%b ARREADY=%b required 0 0", S_AXI_RVALID, S_AXI_ARREADY);
      end
      @(negedge CLK);
      RES_N = 1'b1;
      S_AXI_RREADY = 1'b0;
      @(negedge CLK);
      checks++;
      if (S_AXI_ARREADY !== 1'b1 || S_AXI_RVALID !== 1'b0) begin
         errors++;
         $display("FAIL midrst_release: ARREADY=%b RVALID=%b required 1 0", S_AXI_ARREADY, S_AXI_RVALID);
      end
      run_burst(32'h40, 8'd0, 3'd2, 2'b01, 0, "after_reset_len0");
   endtask

   task automatic test_random();
      for (int i = 0; i < c_DEPTH; i++) mem[i] = $urandom;
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         logic [1:0]  bt;
         case ($urandom_range(0, 3))
            0:       a = 32'($urandom_range(c_DEPTH - 8, c_DEPTH - 1) * 4);
            1:       a = $urandom;
            default: a = 32'($urandom_range(0, c_DEPTH - 1) * 4 + $urandom_range(0, 3));
         endcase
         sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         bt = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         run_burst(a, 8'($urandom_range(0, 15)), sz, bt, $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      RES_N         = 1'b0;
      S_AXI_ARADDR  = '0;
      S_AXI_ARLEN   = '0;
      S_AXI_ARSIZE  = 3'd2;
      S_AXI_ARBURST = 2'b01;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      for (int i = 0; i < c_DEPTH; i++) mem[i] = 32'(i + 32'h100);
      @(negedge CLK);
      test_reset();
      run_burst(32'h0, 8'd7, 3'd2, 2'b01, 0, "incr_basic");
      run_burst(32'h0, 8'd7, 3'd2, 2'b01, 1, "incr_stall");
      run_burst(32'h10, 8'd3, 3'd2, 2'b00, 0, "fixed");
      run_burst(32'((c_DEPTH - 2) * 4), 8'd3, 3'd2, 2'b01, 0, "decerr_cross");
      run_burst(32'h0, 8'd1, 3'd1, 2'b01, 0, "slverr_size");
      run_burst(32'h20, 8'd2, 3'd2, 2'b10, 1, "slverr_wrap");
      run_burst(32'h8, 8'd2, 3'd2, 2'b01, 0, "back_to_back_a");
      run_burst(32'h30, 8'd2, 3'd2, 2'b01, 0, "back_to_back_b");
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
